// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic matmul sequencer.
// Holds the state enum and common widths.
package systolic_pkg;

  localparam int N_DEF     = 4;
  localparam int DRAIN_DEF = 4;
  localparam int COUNT_W   = 6;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    COLLECT,
    DONE
  } seq_state_t;

endpackage

// File: rtl/systolic_sequencer_if.sv
// Host command channel of the sequencer.
// master: host side; slave: sequencer side (start_valid/k_len/abort in, start_ready out).
interface systolic_sequencer_if #(
  parameter int KW = 8
) ();

  logic          start_valid;
  logic          start_ready;
  logic [KW-1:0] k_len;
  logic          abort;

  modport master (
    output start_valid,
    output k_len,
    output abort,
    input  start_ready
  );

  modport slave (
    input  start_valid,
    input  k_len,
    input  abort,
    output start_ready
  );

endinterface

// File: rtl/systolic_sequencer_skew.sv
// Combinational row-skew mask: row i is fed while feed_cnt is in [i, i+k_q).
// Ports: feed_cnt/k_q in, mask out (registered by the parent).
module skew_mask_gen #(
  parameter int N  = 4,
  parameter int KW = 8
) (
  input  logic [KW+4:0] feed_cnt,
  input  logic [KW-1:0] k_q,
  output logic [N-1:0]  mask
);

  localparam int PW = KW + 5;

  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (feed_cnt >= PW'(i)) &&
                (feed_cnt < PW'(i) + PW'(k_q));
    end
  end

endmodule

// File: rtl/systolic_sequencer.sv
// Sequences one NxN output-stationary systolic pass: clear, skewed feed, drain, collect.
// Ports: clk, rst_n, host (start/k_len/abort), acc_clr, feed_en, feed_cnt, count, busy, done.
module systolic_sequencer
  import systolic_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int KW        = 8,
  parameter int DRAIN_CYC = DRAIN_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  systolic_sequencer_if.slave host,
  output logic               acc_clr,
  output logic [N-1:0]       feed_en,
  output logic [KW+4:0]      feed_cnt,
  output logic [COUNT_W-1:0] count,
  output logic               busy,
  output logic               done
);

  localparam int PW = KW + 5;

  seq_state_t    state, nxt;
  logic [PW-1:0] phase, nxt_phase;
  logic [PW-1:0] feed_last;
  logic [KW-1:0] k_q;
  logic [N-1:0]  mask;

  assign feed_last = PW'(k_q) + PW'(N) - PW'(2);
  assign host.start_ready = (state == IDLE);

  // One phase counter serves FEED, DRAIN and COLLECT;
  // it restarts at zero whenever the state changes.
  always_comb begin
    nxt       = state;
    nxt_phase = '0;
    if (host.abort && state != IDLE) begin
      nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (host.start_valid) nxt = CLEAR;
        end
        CLEAR: begin
          nxt = (k_q == '0) ? DRAIN : FEED;
        end
        FEED: begin
          if (phase == feed_last) nxt = DRAIN;
          else nxt_phase = phase + PW'(1);
        end
        DRAIN: begin
          if (phase == PW'(DRAIN_CYC - 1)) nxt = COLLECT;
          else nxt_phase = phase + PW'(1);
        end
        COLLECT: begin
          if (phase == PW'(2 * N - 2)) nxt = DONE;
          else nxt_phase = phase + PW'(1);
        end
        DONE: begin
          nxt = IDLE;
        end
        default: begin
          nxt = IDLE;
        end
      endcase
    end
  end

  skew_mask_gen #(
    .N  (N),
    .KW (KW)
  ) u_skew (
    .feed_cnt (nxt_phase),
    .k_q      (k_q),
    .mask     (mask)
  );

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      phase    <= '0;
      k_q      <= '0;
      acc_clr  <= 1'b0;
      feed_en  <= '0;
      feed_cnt <= '0;
      count    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= nxt;
      phase <= nxt_phase;
      if (state == IDLE && host.start_valid) k_q <= host.k_len;
      acc_clr  <= (nxt == CLEAR);
      feed_en  <= (nxt == FEED) ? mask : '0;
      feed_cnt <= (nxt == FEED) ? nxt_phase : '0;
      count    <= (nxt == COLLECT) ?
                  COUNT_W'(nxt_phase + PW'(1)) : '0;
      busy     <= (nxt != IDLE);
      done     <= (nxt == DONE);
    end
  end

endmodule
